count15_checker: RTL and testbench
==================================

# count15_checker

Synthesizable sequence checker that sits on the observing end of a free-running 4-bit wrap-around counter with synchronous reset. It samples the counter's output and the reset it is driven with, predicts the next value, and flags and accumulates mismatches. It provides in-silicon/FPGA self-check of counter blocks and gives benches a registered pass/fail summary.

## Interface
- WIDTH, 4: counter width. The counter wraps at 2**WIDTH-1 → 0.
- ERR_W, 16: width of the error counter. The counter saturates.
- CYC_W, 16: width of the sample and first-error cycle counters. Both saturate.
- RESYNC, 1: after a mismatch, 1 = adopt the observed value; 0 = keep the own prediction.

- clk  in  1  clock; all sampling on rising edge
- reset  in  1  asynchronous, active-high reset of the checker itself
- dut_reset  in  1  synchronous reset as driven into the observed counter
- q  in  WIDTH  observed counter value
- clear  in  1  synchronous clear of statistics
- locked  out  1  checker is in TRACK
- mismatch  out  1  registered; high one cycle after a bad sample
- sticky_err  out  1  set on any mismatch; held until clear/reset
- err_count  out  ERR_W  number of mismatching samples, saturating
- samples  out  CYC_W  number of compared samples, saturating
- first_err_cycle  out  CYC_W  value of samples at the first mismatch

## Operation
- Internal expected-value register exp (WIDTH bits). The state machine has two states: UNSYNC and TRACK.
- UNSYNC: no comparisons, no stats updates.
  - On an edge with dut_reset=1, set exp←0 and go to TRACK.
- TRACK, every edge:
  - cmp = (q != exp).
  - mismatch←cmp.
  - samples←samples+1 (saturating).
  - If cmp: err_count+1 (saturating); sticky_err←1; if err_count==0, then first_err_cycle←samples (the value before increment).
  - exp update, in priority order:
    - dut_reset=1 → 0
    - cmp and RESYNC=1 → q+1
    - otherwise exp+1
  - All increments of exp are modulo 2**WIDTH (15→0 is legal).
- dut_reset sampled in TRACK does not suppress the comparison at that edge. The counter's q still holds its pre-reset value on that edge, so it is compared against exp as normal.
- clear=1:
  - Zeroes err_count, samples, first_err_cycle, sticky_err and mismatch.
  - The sample at that edge is discarded from the stats; clear wins over a simultaneous mismatch.
  - State and exp update as normal.
- The checker never leaves TRACK except via reset.

## Timing
- reset asserted: immediately (asynchronously) state=UNSYNC, exp=0, and every output = 0, including locked.
- Reset applied mid-operation discards all stats. Resynchronisation then requires a new dut_reset pulse.
- locked rises on the edge that samples the first dut_reset=1.
- First compared sample is on the edge after that, with expected value 0.
- mismatch latency: 1 cycle. The flag is high for the cycle following the edge where the bad q was sampled.
- err_count, samples, sticky_err and first_err_cycle update on the same edge as mismatch.
- Saturation: counters hold at all-ones; no wrap.

## Structure
- Package count15_checker_pkg holds:
  - the state enum {UNSYNC, TRACK}
  - the default parameter constants
- Sub-module sat_counter (parameterised width, inputs inc and clr, async reset) is instantiated twice: once for err_count and once for samples.
- exp, the state machine, first_err_cycle capture and mismatch live in the top module.

## Test plan
- Clean run:
  - Stimulus: reset, one dut_reset pulse, then q = 0..15,0,1 each cycle.
  - Required: mismatch never high, err_count=0, samples=18, locked=1.
- Pre-sync noise:
  - Stimulus: random q for 20 cycles with dut_reset=0.
  - Required: locked=0, samples=0, err_count=0.
- Single glitch, RESYNC=1:
  - Stimulus: q = 0,1,2,9,10,11.
  - Required: mismatch high only in the cycle after q=9; err_count=1; first_err_cycle=3.
- Same glitch, RESYNC=0:
  - Stimulus: q = 0,1,2,9,10,11.
  - Required: err_count=3, sticky_err=1, first_err_cycle=3.
- Mid-count dut_reset:
  - Stimulus: dut_reset sampled while q=7; next q=0, then 1.
  - Required: no mismatch.
- Boundaries:
  - ERR_W=2 with 5 bad samples → err_count=3.
  - clear coincident with a bad sample → all stats 0.
  - Async reset mid-run → all outputs 0 without a clock edge; locked=0 until the next dut_reset.

Source files
------------

// File: rtl/count15_checker_pkg.sv
// Shared types and default parameters for the counter sequence checker.
package count15_checker_pkg;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_ERR_W  = 16;
    localparam int DEF_CYC_W  = 16;
    localparam int DEF_RESYNC = 1;

endpackage

// File: rtl/count15_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count15_checker.sv
// Observes a wrap-around counter, predicts its next value and accumulates mismatch statistics.
//
// state  | meaning
// UNSYNC | waiting for the first dut_reset; no comparisons, stats frozen
// TRACK  | comparing q against the prediction on every edge
module count15_checker
    import count15_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int CYC_W  = DEF_CYC_W,
    parameter int RESYNC = DEF_RESYNC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dut_reset,
    input  logic [WIDTH-1:0] q,
    input  logic             clear,
    output logic             locked,
    output logic             mismatch,
    output logic             sticky_err,
    output logic [ERR_W-1:0] err_count,
    output logic [CYC_W-1:0] samples,
    output logic [CYC_W-1:0] first_err_cycle
);

    state_t           state;
    logic [WIDTH-1:0] exp_val;
    logic             track;
    logic             cmp;

    assign track  = (state == TRACK);
    assign cmp    = track && (q != exp_val);
    assign locked = track;

    // clear discards the sample taken on the same edge, so it masks both increments
    sat_counter #(.W(ERR_W)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .inc   (cmp && !clear),
        .clr   (clear),
        .count (err_count)
    );

    sat_counter #(.W(CYC_W)) u_samples (
        .clk   (clk),
        .reset (reset),
        .inc   (track && !clear),
        .clr   (clear),
        .count (samples)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= UNSYNC;
            exp_val         <= '0;
            mismatch        <= 1'b0;
            sticky_err      <= 1'b0;
            first_err_cycle <= '0;
        end else begin
            case (state)
                UNSYNC: begin
                    if (dut_reset) begin
                        state   <= TRACK;
                        exp_val <= '0;
                    end
                end
                TRACK: begin
                    // a reset edge still compares q, which holds its pre-reset value
                    if (dut_reset) begin
                        exp_val <= '0;
                    end else if (cmp && (RESYNC != 0)) begin
                        exp_val <= q + WIDTH'(1);
                    end else begin
                        exp_val <= exp_val + WIDTH'(1);
                    end
                end
                default: begin
                    state   <= UNSYNC;
                    exp_val <= '0;
                end
            endcase

            if (clear) begin
                mismatch        <= 1'b0;
                sticky_err      <= 1'b0;
                first_err_cycle <= '0;
            end else begin
                mismatch <= cmp;
                if (cmp) begin
                    sticky_err <= 1'b1;
                end
                if (cmp && (err_count == '0)) begin
                    first_err_cycle <= samples;
                end
            end
        end
    end

endmodule

// File: tb/tb_count15_checker.sv
// Bench for count15_checker: a RESYNC=1 instance and a RESYNC=0 / ERR_W=2 instance share stimulus.
module tb_count15_checker;

    typedef struct {
        bit          trk;
        int unsigned ev;
        bit          mm;
        bit          sticky;
        int unsigned err;
        int unsigned samp;
        int unsigned first;
    } model_t;

    typedef struct {
        bit          dr;
        logic [3:0]  qv;
        bit          clr;
        bit          mm_a;
        int unsigned err_a;
        bit          mm_b;
        int unsigned err_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dut_reset = 1'b0;
    logic [3:0]  q = 4'd0;
    logic        clear = 1'b0;

    logic        locked_a, mismatch_a, sticky_a;
    logic [15:0] err_a, samples_a, first_a;
    logic        locked_b, mismatch_b, sticky_b;
    logic [1:0]  err_b;
    logic [15:0] samples_b, first_b;

    int n_tests = 0;
    int n_fail  = 0;

    model_t ma, mb;
    model_t exp_qa[$];
    model_t exp_qb[$];

    count15_checker #(.WIDTH(4), .ERR_W(16), .CYC_W(16), .RESYNC(1)) u_dut_a (
        .clk             (clk),
        .reset           (reset),
        .dut_reset       (dut_reset),
        .q               (q),
        .clear           (clear),
        .locked          (locked_a),
        .mismatch        (mismatch_a),
        .sticky_err      (sticky_a),
        .err_count       (err_a),
        .samples         (samples_a),
        .first_err_cycle (first_a)
    );

    count15_checker #(.WIDTH(4), .ERR_W(2), .CYC_W(16), .RESYNC(0)) u_dut_b (
        .clk             (clk),
        .reset           (reset),
        .dut_reset       (dut_reset),
        .q               (q),
        .clear           (clear),
        .locked          (locked_b),
        .mismatch        (mismatch_b),
        .sticky_err      (sticky_b),
        .err_count       (err_b),
        .samples         (samples_b),
        .first_err_cycle (first_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cmp_val(input string nm, input int unsigned act, input int unsigned req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        ma = '{default: 0};
        mb = '{default: 0};
        exp_qa.delete();
        exp_qb.delete();
    endtask

    task automatic model_step(input model_t m, input bit resync, input int unsigned errmax,
                              input bit dr, input logic [3:0] qv, input bit clr,
                              output model_t n);
        bit bad;
        n = m;
        if (!m.trk) begin
            n.mm = 0;
            if (dr) begin
                n.trk = 1;
                n.ev  = 0;
            end
        end else begin
            bad  = (int'(qv) != m.ev);
            n.mm = bad;
            if (m.samp < 65535) n.samp = m.samp + 1;
            if (bad) begin
                n.sticky = 1;
                if (m.err == 0) n.first = m.samp;
                if (m.err < errmax) n.err = m.err + 1;
            end
            if (dr)                n.ev = 0;
            else if (bad && resync) n.ev = (int'(qv) + 1) % 16;
            else                    n.ev = (m.ev + 1) % 16;
        end
        if (clr) begin
            n.mm = 0; n.sticky = 0; n.err = 0; n.samp = 0; n.first = 0;
        end
    endtask

    task automatic check_pop();
        model_t ea, eb;
        if (exp_qa.size() == 0 || exp_qb.size() == 0) begin
            cmp_val("scoreboard_empty", 0, 1);
            return;
        end
        ea = exp_qa.pop_front();
        eb = exp_qb.pop_front();
        cmp_val("a_locked",   locked_a,   ea.trk);
        cmp_val("a_mismatch", mismatch_a, ea.mm);
        cmp_val("a_sticky",   sticky_a,   ea.sticky);
        cmp_val("a_err",      err_a,      ea.err);
        cmp_val("a_samples",  samples_a,  ea.samp);
        cmp_val("a_first",    first_a,    ea.first);
        cmp_val("b_locked",   locked_b,   eb.trk);
        cmp_val("b_mismatch", mismatch_b, eb.mm);
        cmp_val("b_sticky",   sticky_b,   eb.sticky);
        cmp_val("b_err",      err_b,      eb.err);
        cmp_val("b_samples",  samples_b,  eb.samp);
        cmp_val("b_first",    first_b,    eb.first);
    endtask

    task automatic cycle(input bit dr, input logic [3:0] qv, input bit clr);
        model_t na, nb;
        @(negedge clk);
        dut_reset = dr;
        q         = qv;
        clear     = clr;
        model_step(ma, 1'b1, 65535, dr, qv, clr, na);
        model_step(mb, 1'b0, 3, dr, qv, clr, nb);
        ma = na;
        mb = nb;
        exp_qa.push_back(na);
        exp_qb.push_back(nb);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic check_all_zero(input string tag);
        cmp_val({tag, "_a_outs"}, {locked_a, mismatch_a, sticky_a} | err_a | samples_a | first_a, 0);
        cmp_val({tag, "_b_outs"}, {locked_b, mismatch_b, sticky_b} | err_b | samples_b | first_b, 0);
    endtask

    vec_t tbl[7];

    initial begin
        bit mm_seen;
        model_reset();

        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // pre-sync noise
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0);
        cmp_val("presync_locked",  locked_a,  0);
        cmp_val("presync_samples", samples_a, 0);
        cmp_val("presync_err",     err_a,     0);

        // clean run
        cycle(1'b1, 4'd5, 1'b0);
        cmp_val("lock_rise", locked_a, 1);
        mm_seen = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, 4'(i % 16), 1'b0);
            mm_seen |= mismatch_a | mismatch_b;
        end
        cmp_val("clean_mismatch_seen", mm_seen, 0);
        cmp_val("clean_err",     err_a,     0);
        cmp_val("clean_samples", samples_a, 18);
        cmp_val("clean_locked",  locked_a,  1);

        // single glitch, both RESYNC settings; first row restarts stats with clear
        tbl[0] = '{1'b1, 4'd15, 1'b1, 1'b0, 0, 1'b0, 0};
        tbl[1] = '{1'b0, 4'd0,  1'b0, 1'b0, 0, 1'b0, 0};
        tbl[2] = '{1'b0, 4'd1,  1'b0, 1'b0, 0, 1'b0, 0};
        tbl[3] = '{1'b0, 4'd2,  1'b0, 1'b0, 0, 1'b0, 0};
        tbl[4] = '{1'b0, 4'd9,  1'b0, 1'b1, 1, 1'b1, 1};
        tbl[5] = '{1'b0, 4'd10, 1'b0, 1'b0, 1, 1'b1, 2};
        tbl[6] = '{1'b0, 4'd11, 1'b0, 1'b0, 1, 1'b1, 3};
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].dr, tbl[i].qv, tbl[i].clr);
            cmp_val($sformatf("tbl%0d_mm_a", i),  mismatch_a, tbl[i].mm_a);
            cmp_val($sformatf("tbl%0d_err_a", i), err_a,      tbl[i].err_a);
            cmp_val($sformatf("tbl%0d_mm_b", i),  mismatch_b, tbl[i].mm_b);
            cmp_val($sformatf("tbl%0d_err_b", i), err_b,      tbl[i].err_b);
        end
        cmp_val("glitch_first_a",  first_a,  3);
        cmp_val("glitch_first_b",  first_b,  3);
        cmp_val("glitch_sticky_a", sticky_a, 1);
        cmp_val("glitch_sticky_b", sticky_b, 1);

        // clear coincident with a bad sample
        cycle(1'b1, 4'd15, 1'b1);
        cmp_val("clrbad_mm_a",     mismatch_a, 0);
        cmp_val("clrbad_sticky_a", sticky_a,   0);
        cmp_val("clrbad_err_a",    err_a,      0);
        cmp_val("clrbad_samp_a",   samples_a,  0);
        cmp_val("clrbad_err_b",    err_b,      0);
        cmp_val("clrbad_sticky_b", sticky_b,   0);

        // mid-count dut_reset while q=7
        for (int i = 0; i < 7; i++) cycle(1'b0, 4'(i), 1'b0);
        cycle(1'b1, 4'd7, 1'b0);
        cycle(1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'd1, 1'b0);
        cmp_val("midrst_err_a",    err_a,    0);
        cmp_val("midrst_err_b",    err_b,    0);
        cmp_val("midrst_sticky_a", sticky_a, 0);

        // five bad samples: saturation of the 2-bit error counter
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'd8, 1'b0);
        cmp_val("sat_err_a", err_a, 5);
        cmp_val("sat_err_b", err_b, 3);
        cmp_val("sat_first_a", first_a, 10);

        // async reset mid-cycle, no clock edge before the check
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'(i), 1'b0);
        cmp_val("post_reset_locked_a", locked_a, 0);
        cmp_val("post_reset_locked_b", locked_b, 0);
        cycle(1'b1, 4'd3, 1'b0);
        cmp_val("relock_a", locked_a, 1);
        cycle(1'b0, 4'd0, 1'b0);
        cmp_val("relock_samples_a", samples_a, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
